// File: rtl/fetch_unit_pkg.sv
// Shared RV32I type definitions used by the fetch stage and its bench.
//
// Contents:
//   rv32i_word   32-bit architectural word (addresses and instructions)
//   RESET_PC     address fetched first after reset
//   pc_add4      sequential successor of a PC, wrapping at 2^32
//   word_align   forces the two low address bits to zero
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  localparam rv32i_word RESET_PC = 32'h0000_0060;

  // Plain 32-bit addition; the carry out of bit 31 is dropped so
  // 32'hFFFF_FFFC rolls over to 32'h0000_0000.
  function automatic rv32i_word pc_add4(input rv32i_word pc);
    return pc + 32'd4;
  endfunction

  function automatic rv32i_word word_align(input rv32i_word addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// I-cache read channel between the fetch unit and the instruction cache.
//
// Signals:
//   icache_read_out  fetch -> cache  read request, held until icache_resp_in
//   icache_addr_out  fetch -> cache  request address, stable while requesting
//   icache_resp_in   cache -> fetch  read complete this cycle
//   icache_rdata_in  cache -> fetch  instruction word, valid with the response
//
// Modports: master (fetch unit side), slave (i-cache side).
interface fetch_unit_if;
  import rv32i_types::*;

  logic      icache_read_out;
  rv32i_word icache_addr_out;
  logic      icache_resp_in;
  rv32i_word icache_rdata_in;

  modport master (
    output icache_read_out,
    output icache_addr_out,
    input  icache_resp_in,
    input  icache_rdata_in
  );

  modport slave (
    input  icache_read_out,
    input  icache_addr_out,
    output icache_resp_in,
    output icache_rdata_in
  );

endinterface

// File: rtl/fetch_unit_hold_buf.sv
// fetch_hold_buf: holding register for an instruction that arrived while the
// decode stage was stalled, together with the BTB bits looked up for it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load                     capture instr_in/btb_hit_in/btb_taken_in
//   clear                    empty the buffer (clear wins over load)
//   instr_in, btb_hit_in,
//   btb_taken_in             word and prediction bits to capture
//   instr, btb_hit,
//   btb_taken                buffered contents
module fetch_hold_buf
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  rv32i_word instr_in,
  input  logic      btb_hit_in,
  input  logic      btb_taken_in,
  output rv32i_word instr,
  output logic      btb_hit,
  output logic      btb_taken
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr     <= '0;
      btb_hit   <= 1'b0;
      btb_taken <= 1'b0;
    end else if (clear) begin
      instr     <= '0;
      btb_hit   <= 1'b0;
      btb_taken <= 1'b0;
    end else if (load) begin
      instr     <= instr_in;
      btb_hit   <= btb_hit_in;
      btb_taken <= btb_taken_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues one i-cache read per PC,
// presents the returned word to IF/ID, buffers it while decode is stalled and
// abandons in-flight reads when the EX stage redirects the PC.
//
// Build option: FETCH_BTB_PREDICT_EN -- when defined, a BTB hit+taken steers
// the next PC to btb_target_in and the BTB bits are forwarded downstream;
// when undefined the BTB inputs are ignored and fetch is purely sequential.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall_in          IF/ID cannot load this cycle
//   redirect_in       EX-stage redirect, highest priority
//   redirect_pc_in    redirect target (low two bits ignored)
//   btb_hit_in, btb_taken_in, btb_target_in   BTB lookup for pc_out
//   icache            i-cache read channel (master side)
//   pc_out, pc_plus4_out   PC of the presented instruction and PC+4
//   instr_out         presented instruction word
//   btb_hit_out, btb_taken_out   prediction bits of the presented instruction
//   valid_out         instruction presented; IF/ID loads when valid && !stall
module fetch_unit
  import rv32i_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                redirect_in,
  input  rv32i_word           redirect_pc_in,
  input  logic                btb_hit_in,
  input  logic                btb_taken_in,
  input  rv32i_word           btb_target_in,
  fetch_unit_if.master        icache,
  output rv32i_word           pc_out,
  output rv32i_word           pc_plus4_out,
  output rv32i_word           instr_out,
  output logic                btb_hit_out,
  output logic                btb_taken_out,
  output logic                valid_out
);

  // FETCH: read outstanding at pc. HOLD: word buffered, decode stalled.
  // DROP: a read issued before a redirect is still in flight and its word
  // must be thrown away when it returns.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  fetch_state_e state;
  rv32i_word    pc;
  rv32i_word    req_addr;

  rv32i_word    hold_instr;
  logic         hold_hit;
  logic         hold_taken;
  logic         buf_load;
  logic         buf_clear;

  rv32i_word    redirect_pc;
  rv32i_word    next_pc_live;
  rv32i_word    next_pc_held;

  assign redirect_pc = word_align(redirect_pc_in);

  // The live BTB bits belong to the word arriving in FETCH; once a word is
  // parked in HOLD its own captured bits decide the successor. The target
  // is still looked up for pc, which does not move while holding.
`ifdef FETCH_BTB_PREDICT_EN
  assign next_pc_live = (btb_hit_in && btb_taken_in) ? btb_target_in : pc_add4(pc);
  assign next_pc_held = (hold_hit && hold_taken) ? btb_target_in : pc_add4(pc);

  logic unused_bits;
  assign unused_bits = ^redirect_pc_in[1:0];
`else
  assign next_pc_live = pc_add4(pc);
  assign next_pc_held = pc_add4(pc);

  logic unused_bits;
  assign unused_bits = ^{redirect_pc_in[1:0], btb_target_in, hold_hit, hold_taken};
`endif

  assign buf_load  = (state == S_FETCH) && icache.icache_resp_in && !redirect_in && stall_in;
  assign buf_clear = (state == S_HOLD) && (redirect_in || !stall_in);

  fetch_hold_buf u_hold_buf (
    .clk          (clk),
    .rst          (rst),
    .load         (buf_load),
    .clear        (buf_clear),
    .instr_in     (icache.icache_rdata_in),
    .btb_hit_in   (btb_hit_in),
    .btb_taken_in (btb_taken_in),
    .instr        (hold_instr),
    .btb_hit      (hold_hit),
    .btb_taken    (hold_taken)
  );

  // State, PC and the address of an abandoned request. A redirect always
  // replaces pc; what happens to the in-flight read depends on the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      req_addr <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (redirect_in) begin
            pc <= redirect_pc;
            if (!icache.icache_resp_in) begin
              req_addr <= pc;
              state    <= S_DROP;
            end
          end else if (icache.icache_resp_in) begin
            if (stall_in) begin
              state <= S_HOLD;
            end else begin
              pc <= next_pc_live;
            end
          end
        end
        S_HOLD: begin
          if (redirect_in) begin
            pc    <= redirect_pc;
            state <= S_FETCH;
          end else if (!stall_in) begin
            pc    <= next_pc_held;
            state <= S_FETCH;
          end
        end
        S_DROP: begin
          if (redirect_in) begin
            pc <= redirect_pc;
          end
          if (icache.icache_resp_in) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Presented instruction and cache request. Everything is forced quiet while
  // rst is high so neither the cache nor decode sees a request mid-reset.
  always_comb begin
    icache.icache_read_out = 1'b0;
    icache.icache_addr_out = pc;
    valid_out              = 1'b0;
    instr_out              = '0;
    btb_hit_out            = 1'b0;
    btb_taken_out          = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          icache.icache_read_out = 1'b1;
          icache.icache_addr_out = pc;
          valid_out              = icache.icache_resp_in && !redirect_in;
          instr_out              = icache.icache_rdata_in;
`ifdef FETCH_BTB_PREDICT_EN
          btb_hit_out            = btb_hit_in;
          btb_taken_out          = btb_taken_in;
`endif
        end
        S_HOLD: begin
          valid_out     = !redirect_in;
          instr_out     = hold_instr;
`ifdef FETCH_BTB_PREDICT_EN
          btb_hit_out   = hold_hit;
          btb_taken_out = hold_taken;
`endif
        end
        S_DROP: begin
          icache.icache_read_out = 1'b1;
          icache.icache_addr_out = req_addr;
        end
        default: begin
          icache.icache_read_out = 1'b0;
        end
      endcase
    end
  end

  assign pc_out       = pc;
  assign pc_plus4_out = pc_add4(pc);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Directed scenarios for
// reset, streaming, stall/hold, redirect-drop, BTB steering and PC wrap,
// followed by randomized traffic checked against a transaction-level model
// (program counter, an optional abandoned request, an optional parked word).
// Honours FETCH_BTB_PREDICT_EN the same way as the design.
module tb_fetch_unit;
  import rv32i_types::*;

`ifdef FETCH_BTB_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      stall_in = 1'b0;
  logic      redirect_in = 1'b0;
  rv32i_word redirect_pc_in = '0;
  logic      btb_hit_in = 1'b0;
  logic      btb_taken_in = 1'b0;
  rv32i_word btb_target_in = '0;
  rv32i_word pc_out;
  rv32i_word pc_plus4_out;
  rv32i_word instr_out;
  logic      btb_hit_out;
  logic      btb_taken_out;
  logic      valid_out;

  fetch_unit_if icache_bus ();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .btb_hit_in     (btb_hit_in),
    .btb_taken_in   (btb_taken_in),
    .btb_target_in  (btb_target_in),
    .icache         (icache_bus),
    .pc_out         (pc_out),
    .pc_plus4_out   (pc_plus4_out),
    .instr_out      (instr_out),
    .btb_hit_out    (btb_hit_out),
    .btb_taken_out  (btb_taken_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: the PC being fetched, an abandoned request still owed
  // by the cache, and a word waiting for decode to accept it.
  rv32i_word m_pc;
  bit        m_stale;
  rv32i_word m_stale_addr;
  bit        m_held;
  rv32i_word m_word;
  bit        m_hbit;
  bit        m_tbit;

  // Contents of instruction memory as seen through the cache.
  function automatic rv32i_word memWord(input rv32i_word a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Drives one cycle of inputs; the cache returns the word at the address
  // the model says is being requested.
  task automatic applyStimulus(input bit stall, input bit redir, input rv32i_word rpc,
                               input bit hit, input bit taken, input rv32i_word tgt,
                               input bit resp);
    stall_in                   = stall;
    redirect_in                = redir;
    redirect_pc_in             = rpc;
    btb_hit_in                 = hit;
    btb_taken_in               = taken;
    btb_target_in              = tgt;
    icache_bus.icache_resp_in  = resp;
    icache_bus.icache_rdata_in = memWord(m_stale ? m_stale_addr : m_pc);
  endtask

  task automatic modelCheck();
    bit exp_read, exp_valid, exp_hit, exp_taken;
    exp_read  = !m_held;
    exp_valid = !redirect_in && (m_held || (!m_stale && icache_bus.icache_resp_in));
    checkOutput("read", icache_bus.icache_read_out, exp_read);
    if (exp_read)
      checkOutput("addr", icache_bus.icache_addr_out, m_stale ? m_stale_addr : m_pc);
    checkOutput("valid", valid_out, exp_valid);
    if (exp_valid) begin
      checkOutput("instr", instr_out, m_held ? m_word : memWord(m_pc));
      exp_hit   = PRED && (m_held ? m_hbit : btb_hit_in);
      exp_taken = PRED && (m_held ? m_tbit : btb_taken_in);
      checkOutput("btb_hit", btb_hit_out, exp_hit);
      checkOutput("btb_taken", btb_taken_out, exp_taken);
    end
    checkOutput("pc", pc_out, m_pc);
    checkOutput("pc_plus4", pc_plus4_out, m_pc + 32'd4);
  endtask

  function automatic rv32i_word successor(input bit h, input bit t);
    return (PRED && h && t) ? btb_target_in : m_pc + 32'd4;
  endfunction

  task automatic modelUpdate();
    bit resp;
    resp = icache_bus.icache_resp_in;
    if (redirect_in) begin
      if (m_stale) begin
        if (resp) m_stale = 1'b0;
      end else if (!m_held && !resp) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end
      m_held = 1'b0;
      m_pc   = redirect_pc_in & 32'hFFFF_FFFC;
    end else if (m_stale) begin
      if (resp) m_stale = 1'b0;
    end else if (m_held) begin
      if (!stall_in) begin
        m_pc   = successor(m_hbit, m_tbit);
        m_held = 1'b0;
      end
    end else if (resp) begin
      if (stall_in) begin
        m_held = 1'b1;
        m_word = memWord(m_pc);
        m_hbit = btb_hit_in;
        m_tbit = btb_taken_in;
      end else begin
        m_pc = successor(btb_hit_in, btb_taken_in);
      end
    end
  endtask

  // Checks the settled outputs, advances the model, crosses the clock edge.
  task automatic commit();
    modelCheck();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  // Asserts rst mid-cycle with a noisy cache/BTB to confirm the outputs are
  // forced quiet at once, then releases it just after a rising edge.
  task automatic doReset();
    @(posedge clk);
    #2;
    rst                        = 1'b1;
    stall_in                   = 1'b0;
    redirect_in                = 1'b0;
    btb_hit_in                 = 1'b1;
    btb_taken_in               = 1'b1;
    btb_target_in              = 32'h0000_0400;
    icache_bus.icache_resp_in  = 1'b1;
    icache_bus.icache_rdata_in = 32'hDEAD_BEEF;
    #1;
    checkOutput("rst_pc", pc_out, RESET_PC);
    checkOutput("rst_read", icache_bus.icache_read_out, 1'b0);
    checkOutput("rst_valid", valid_out, 1'b0);
    checkOutput("rst_instr", instr_out, 32'h0);
    checkOutput("rst_btb_hit", btb_hit_out, 1'b0);
    checkOutput("rst_btb_taken", btb_taken_out, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst                       = 1'b0;
    btb_hit_in                = 1'b0;
    btb_taken_in              = 1'b0;
    icache_bus.icache_resp_in = 1'b0;
    m_pc    = RESET_PC;
    m_stale = 1'b0;
    m_held  = 1'b0;
  endtask

  task automatic streamCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      commit();
    end
  endtask

  initial begin
    icache_bus.icache_resp_in  = 1'b0;
    icache_bus.icache_rdata_in = '0;
    m_pc = RESET_PC; m_stale = 1'b0; m_stale_addr = '0;
    m_held = 1'b0; m_word = '0; m_hbit = 1'b0; m_tbit = 1'b0;

    // Streaming from reset: one instruction per cycle.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkOutput("stream_read", icache_bus.icache_read_out, 1'b1);
      checkOutput("stream_addr", icache_bus.icache_addr_out, 32'h60 + 32'(4 * i));
      checkOutput("stream_valid", valid_out, 1'b1);
      commit();
    end

    // Stall while the word at 0x64 arrives: held, then 0x68 fetched.
    doReset();
    streamCycles(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("stall_addr", icache_bus.icache_addr_out, 32'h64);
    checkOutput("stall_valid", valid_out, 1'b1);
    commit();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("hold_read", icache_bus.icache_read_out, 1'b0);
      checkOutput("hold_valid", valid_out, 1'b1);
      checkOutput("hold_instr", instr_out, memWord(32'h64));
      commit();
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("release_instr", instr_out, memWord(32'h64));
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("after_hold_addr", icache_bus.icache_addr_out, 32'h68);
    commit();

    // Redirect to 0x200 while 0x70 is outstanding.
    doReset();
    streamCycles(4);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("redir_addr", icache_bus.icache_addr_out, 32'h70);
    checkOutput("redir_valid", valid_out, 1'b0);
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("drop_read", icache_bus.icache_read_out, 1'b1);
    checkOutput("drop_addr", icache_bus.icache_addr_out, 32'h70);
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("drop_resp_addr", icache_bus.icache_addr_out, 32'h70);
    checkOutput("drop_resp_valid", valid_out, 1'b0);
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("target_addr", icache_bus.icache_addr_out, 32'h200);
    checkOutput("target_instr", instr_out, memWord(32'h200));
    commit();

    // BTB hit+taken at 0x80 towards 0x400.
    doReset();
    streamCycles(8);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h400, 1'b1);
    @(negedge clk);
    checkOutput("btb_addr", icache_bus.icache_addr_out, 32'h80);
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
`ifdef FETCH_BTB_PREDICT_EN
    checkOutput("btb_next_addr", icache_bus.icache_addr_out, 32'h400);
`else
    checkOutput("btb_next_addr", icache_bus.icache_addr_out, 32'h84);
`endif
    commit();

    // PC wrap at the top of the address space; low target bits ignored.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_addr", icache_bus.icache_addr_out, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", pc_plus4_out, 32'h0);
    checkOutput("wrap_valid", valid_out, 1'b1);
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("wrap_next_addr", icache_bus.icache_addr_out, 32'h0);
    commit();

    // Reset in the middle of a dropped request.
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    commit();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_drop_addr", icache_bus.icache_addr_out, 32'h0);
    commit();
    doReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_addr", icache_bus.icache_addr_out, 32'h60);
    checkOutput("post_rst_valid", valid_out, 1'b1);
    checkOutput("post_rst_instr", instr_out, memWord(32'h60));
    commit();

    $display("[TB] directed scenarios complete, starting random traffic");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) == 0,
                    $urandom(),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1,
                    $urandom() & 32'hFFFF_FFFC,
                    $urandom_range(0, 9) < 6);
      @(negedge clk);
      commit();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0060, PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stall_in  in  1  downstream hazard; IF/ID must not load this cycle.
REQ-005 redirect_in  in  1  EX-stage mispredict/jump; fetch restarts at redirect_pc_in.
REQ-006 redirect_pc_in  in  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-007 btb_hit_in, btb_taken_in  in  1 each  BTB lookup result for pc_out.
REQ-008 btb_target_in  in  32  BTB predicted target for pc_out.
REQ-009 icache_resp_in  in  1  i-cache read complete.
REQ-010 icache_rdata_in  in  32  instruction word, valid with icache_resp_in.
REQ-011 icache_read_out  out  1  read request; held high until icache_resp_in.
REQ-012 icache_addr_out  out  32  request address; stable while icache_read_out high.
REQ-013 pc_out, pc_plus4_out  out  32 each  PC of presented instruction, and PC+4.
REQ-014 instr_out  out  32  presented instruction word.
REQ-015 btb_hit_out, btb_taken_out  out  1 each  prediction bits for presented instruction.
REQ-016 valid_out  out  1  instruction presented; IF/ID loads when valid_out && !stall_in.

Function
REQ-017 States: FETCH (request outstanding at pc), HOLD (word buffered, downstream stalled), DROP (stale request outstanding after redirect).
REQ-018 FETCH: icache_read_out=1, icache_addr_out=pc; valid_out=icache_resp_in && !redirect_in; instr_out=icache_rdata_in.
REQ-019 FETCH, resp, no redirect, !stall_in: pc<=next_pc, stay FETCH (one instruction per cycle on hits).
REQ-020 FETCH, resp, no redirect, stall_in: buffer instr and BTB bits, go HOLD.
REQ-021 HOLD: icache_read_out=0, valid_out=1, instr_out=buffer; on !stall_in pc<=next_pc, go FETCH.
REQ-022 FETCH, redirect_in, no resp: req_addr<=pc, pc<=redirect_pc_in, go DROP.
REQ-023 FETCH with resp or HOLD, plus redirect_in: discard word, valid_out=0, pc<=redirect_pc_in, go/stay FETCH.
REQ-024 DROP: icache_read_out=1, icache_addr_out=req_addr, valid_out=0; on resp discard word, go FETCH.
REQ-025 DROP, redirect_in: pc<=redirect_pc_in (latest wins); on that cycle's resp go FETCH, else stay DROP.
REQ-026 redirect_in has priority over stall_in and icache_resp_in.
REQ-027 next_pc = pc+4 modulo 2^32 (32'hFFFF_FFFC -> 0), except as in REQ-037.
REQ-028 pc_plus4_out = pc_out+4, same wrap rule; pc_out = pc in all states.

Reset
REQ-029 rst asserted: state=FETCH, pc=RESET_PC, req_addr=0, buffer=0, immediately, independent of clk.
REQ-030 While rst high: icache_read_out=0, valid_out=0, instr_out=0, btb outputs 0.
REQ-031 First rising edge after rst deasserts: icache_read_out=1, icache_addr_out=RESET_PC.
REQ-032 Reset mid-request abandons it; i-cache is reset by the same rst.

Configuration
REQ-033 Macro FETCH_BTB_PREDICT_EN.
REQ-034 Defined: next_pc=btb_target_in when btb_hit_in && btb_taken_in, else pc+4; BTB bits passed to outputs.
REQ-035 Undefined: BTB inputs ignored, next_pc always pc+4, btb_hit_out=btb_taken_out=0.
REQ-036 Redirect handling identical in both builds.
REQ-037 Predicted target used in REQ-019 and REQ-021 uses BTB bits captured with that instruction.

Structure
REQ-038 rv32i_word and RESET_PC constant in shared rv32i_types package; fetch state enum local.
REQ-039 One sub-module fetch_hold_buf: registered instruction + BTB bits, load/clear.

Verification
REQ-040 Reset release, resp every cycle, no stall -> addresses 0x60,0x64,0x68; valid_out=1 each resp cycle.
REQ-041 resp at 0x64 with stall_in 3 cycles -> HOLD, valid_out=1, instr stable, read=0; fetch 0x68 after release.
REQ-042 redirect to 0x200 while 0x70 outstanding -> addr held 0x70 until resp, word dropped, next addr 0x200.
REQ-043 BTB hit+taken target 0x400 at 0x80 (macro on) -> next addr 0x400; macro off -> 0x84.
REQ-044 pc 0xFFFF_FFFC resp, no stall -> next addr 0x0000_0000, pc_plus4_out=0.
REQ-045 rst pulse mid-DROP -> read=0 during rst; first request after release at 0x60, no stale word.
